// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: sequencer state encoding, PC constants and the pending-redirect
// record shared by the PC sequencer and its redirect latch.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

    typedef struct packed {
        logic        valid;
        logic        is_branch;
        logic [31:0] target;
    } redirect_t;

    // Fold this cycle's redirects into a held one. A branch always replaces
    // what is held; a jump replaces anything except a held branch, because
    // the branch belongs to an older instruction.
    function automatic redirect_t merge_redirect(
        input redirect_t   held,
        input logic        branch,
        input logic [31:0] branch_target,
        input logic        jump,
        input logic [31:0] jump_target
    );
        redirect_t r;
        r = held;
        if (branch) begin
            r = '{valid: 1'b1, is_branch: 1'b1, target: branch_target};
        end else if (jump && !(held.valid && held.is_branch)) begin
            r = '{valid: 1'b1, is_branch: 1'b0, target: jump_target};
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: pipeline-facing signals of the PC sequencer.
// Optional feature macro: PC_SEQUENCER_EXCEPTION_EN adds ExcReq / EPC.
interface pc_sequencer_if;
    logic [31:0] PCCurrent;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        LoadUseHazard;
    logic        ICacheReady;
    logic        Halt;
    logic        Resume;
    logic [31:0] PCNext;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic [15:0] StallCycles;
`ifdef PC_SEQUENCER_EXCEPTION_EN
    logic        ExcReq;
    logic [31:0] EPC;
`endif

    // Pipeline side: drives PC state and events, consumes PC control.
    modport master (
        output PCCurrent, BranchTaken, BranchTarget, Jump, JumpTarget,
               LoadUseHazard, ICacheReady, Halt, Resume,
`ifdef PC_SEQUENCER_EXCEPTION_EN
        output ExcReq,
        input  EPC,
`endif
        input  PCNext, PCWrite, IFIDWrite, IFIDFlush, StallCycles
    );

    // Sequencer side.
    modport slave (
        input  PCCurrent, BranchTaken, BranchTarget, Jump, JumpTarget,
               LoadUseHazard, ICacheReady, Halt, Resume,
`ifdef PC_SEQUENCER_EXCEPTION_EN
        input  ExcReq,
        output EPC,
`endif
        output PCNext, PCWrite, IFIDWrite, IFIDFlush, StallCycles
    );
endinterface

// File: rtl/pc_redirect_latch.sv
// pc_redirect_latch: holds a redirect that arrived while fetch could not
// take it, and presents the held redirect merged with this cycle's inputs.
module pc_redirect_latch
    import pc_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_capture,
    input  logic        i_clear,
    input  logic        i_branch,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output redirect_t   o_merged
);
    redirect_t r_latch;

    assign o_merged = merge_redirect(r_latch, i_branch, i_branch_target,
                                     i_jump, i_jump_target);

    // Pending redirect register; an applied/discarded redirect (clear) wins over capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_latch <= '0;
        end else if (i_clear) begin
            r_latch <= '0;
        end else if (i_capture) begin
            r_latch <= o_merged;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: chooses the next PC (sequential, branch/jump redirect,
// stall, halt) and drives the PC and IF/ID pipeline register controls.
// Optional feature macro: PC_SEQUENCER_EXCEPTION_EN adds an exception
// request that vectors fetch to EXC_VECTOR and records the faulting PC.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    state_t      r_state;
    state_t      w_state_next;
    redirect_t   w_merged;
    logic        w_capture;
    logic        w_clear;
    logic [31:0] w_pc_inc;
    logic [31:0] w_pc_next;
    logic        w_pc_write;
    logic        w_ifid_write;
    logic        w_ifid_flush;
    logic [15:0] r_stall_cycles;

    assign w_pc_inc = bus.PCCurrent + PC_INC;

    pc_redirect_latch u_redirect_latch (
        .i_clk           (Clk),
        .i_rst           (Reset),
        .i_capture       (w_capture),
        .i_clear         (w_clear),
        .i_branch        (bus.BranchTaken),
        .i_branch_target (bus.BranchTarget),
        .i_jump          (bus.Jump),
        .i_jump_target   (bus.JumpTarget),
        .o_merged        (w_merged)
    );

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and PC control decode; Halt outranks everything but an exception.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        w_state_next = r_state;
        w_pc_next    = bus.PCCurrent;
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_ifid_flush = 1'b0;
        w_capture    = 1'b0;
        w_clear      = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (bus.Halt) begin
                    w_state_next = ST_HALT;
                end else if (!bus.ICacheReady) begin
                    w_state_next = ST_WAIT;
                    w_capture    = 1'b1;
                end else if (w_merged.valid) begin
                    w_pc_next    = w_merged.target;
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_clear      = 1'b1;
                end else if (!bus.LoadUseHazard) begin
                    w_pc_next    = w_pc_inc;
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.Halt) begin
                    w_state_next = ST_HALT;
                end else if (!bus.ICacheReady) begin
                    w_capture = 1'b1;
                end else begin
                    w_state_next = ST_RUN;
                    w_pc_next    = w_merged.valid ? w_merged.target : w_pc_inc;
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                    w_ifid_flush = w_merged.valid;
                    w_clear      = 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.Resume && !bus.Halt) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
`ifdef PC_SEQUENCER_EXCEPTION_EN
        if (bus.ExcReq) begin
            w_state_next = ST_RUN;
            w_pc_next    = EXC_VECTOR;
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b1;
            w_capture    = 1'b0;
            w_clear      = 1'b1;
        end
`endif
    end

    // Count fetch stalls outside HALT, saturating at all-ones.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cycles <= '0;
        end else if (!w_pc_write && (r_state != ST_HALT) && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

`ifdef PC_SEQUENCER_EXCEPTION_EN
    logic [31:0] r_epc;

    // Record the PC of the instruction that took the exception.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_epc <= '0;
        end else if (bus.ExcReq) begin
            r_epc <= bus.PCCurrent;
        end
    end

    assign bus.EPC = r_epc;
`endif

    // Controls are held quiet while reset is asserted.
    assign bus.PCNext      = Reset ? 32'h0000_0000 : w_pc_next;
    assign bus.PCWrite     = Reset ? 1'b0 : w_pc_write;
    assign bus.IFIDWrite   = Reset ? 1'b0 : w_ifid_write;
    assign bus.IFIDFlush   = Reset ? 1'b0 : w_ifid_flush;
    assign bus.StallCycles = r_stall_cycles;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven RUN-state vectors, hand-written multi-cycle
// sequences and randomized stimulus against a cycle-level behavioural model.
// Optional feature macro: PC_SEQUENCER_EXCEPTION_EN enables exception checks.
module tb_pc_sequencer;

    typedef struct packed {
        logic        rst;
        logic [31:0] pc;
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        luh;
        logic        rdy;
        logic        halt;
        logic        resume;
        logic        exc;
    } in_t;

    typedef struct packed {
        logic [31:0] pc_next;
        logic        pc_write;
        logic        ifid_write;
        logic        ifid_flush;
    } out_t;

    typedef struct packed {
        in_t         in;
        logic [31:0] e_pc_next;
        logic        e_pcw;
        logic        e_ifw;
        logic        e_fl;
        logic [15:0] e_stall;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic        is_br;
        logic [31:0] tgt;
    } pend_t;

    logic clk;
    logic rst;
    pc_sequencer_if bus ();

    pc_sequencer dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic        m_halted;
    logic        m_waiting;
    pend_t       m_pend;
    logic [15:0] m_stall;
    logic [31:0] m_epc;

    out_t        a_out;
    logic [15:0] a_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic in_t idle(input logic [31:0] pc);
        in_t v;
        v = '0;
        v.pc  = pc;
        v.rdy = 1'b1;
        return v;
    endfunction

    task automatic drive(input in_t v);
        rst                = v.rst;
        bus.PCCurrent      = v.pc;
        bus.BranchTaken    = v.br;
        bus.BranchTarget   = v.bt;
        bus.Jump           = v.j;
        bus.JumpTarget     = v.jt;
        bus.LoadUseHazard  = v.luh;
        bus.ICacheReady    = v.rdy;
        bus.Halt           = v.halt;
        bus.Resume         = v.resume;
`ifdef PC_SEQUENCER_EXCEPTION_EN
        bus.ExcReq         = v.exc;
`endif
    endtask

    // Which redirect would fetch see now: held one combined with this cycle's.
    function automatic pend_t effective(input in_t v);
        pend_t p;
        p = m_pend;
        if (v.br) p = '{valid: 1'b1, is_br: 1'b1, tgt: v.bt};
        else if (v.j && !(m_pend.valid && m_pend.is_br)) p = '{valid: 1'b1, is_br: 1'b0, tgt: v.jt};
        return p;
    endfunction

    function automatic out_t model_eval(input in_t v);
        out_t  o;
        pend_t p;
        o = '0;
        if (v.rst) return o;
`ifdef PC_SEQUENCER_EXCEPTION_EN
        if (v.exc) return '{pc_next: 32'h8000_0180, pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1};
`endif
        if (m_halted || v.halt || !v.rdy) return o;
        p = effective(v);
        if (p.valid) return '{pc_next: p.tgt, pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1};
        if (v.luh && !m_waiting) return o;
        return '{pc_next: v.pc + 32'd4, pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0};
    endfunction

    task automatic model_update(input in_t v, input out_t o);
        if (v.rst) begin
            m_halted = 1'b0; m_waiting = 1'b0; m_pend = '0; m_stall = '0; m_epc = '0;
            return;
        end
`ifdef PC_SEQUENCER_EXCEPTION_EN
        if (v.exc) begin
            m_halted = 1'b0; m_waiting = 1'b0; m_pend = '0; m_epc = v.pc;
            return;
        end
`endif
        if (!o.pc_write && !m_halted && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (m_halted) begin
            if (v.resume && !v.halt) m_halted = 1'b0;
            return;
        end
        if (v.halt) begin
            m_halted = 1'b1; m_waiting = 1'b0;
            return;
        end
        if (!v.rdy) begin
            m_pend    = effective(v);
            m_waiting = 1'b1;
        end else begin
            m_waiting = 1'b0;
            m_pend    = '0;
        end
    endtask

    // One clock: drive at negedge, sample combinational outputs, clock, sample state.
    task automatic run_cycle(input in_t v, input string tag);
        out_t e;
        @(negedge clk);
        drive(v);
        #1;
        a_out.pc_next    = bus.PCNext;
        a_out.pc_write   = bus.PCWrite;
        a_out.ifid_write = bus.IFIDWrite;
        a_out.ifid_flush = bus.IFIDFlush;
        e = model_eval(v);
        check({tag, "_pcwrite"},   32'(a_out.pc_write),   32'(e.pc_write));
        check({tag, "_ifidwrite"}, 32'(a_out.ifid_write), 32'(e.ifid_write));
        check({tag, "_ifidflush"}, 32'(a_out.ifid_flush), 32'(e.ifid_flush));
        if (e.pc_write || v.rst) check({tag, "_pcnext"}, a_out.pc_next, e.pc_next);
        @(posedge clk);
        #1;
        model_update(v, e);
        a_stall = bus.StallCycles;
        check({tag, "_stall"}, 32'(a_stall), 32'(m_stall));
`ifdef PC_SEQUENCER_EXCEPTION_EN
        check({tag, "_epc"}, bus.EPC, m_epc);
`endif
    endtask

    task automatic do_reset();
        in_t v;
        v = idle(32'h0);
        v.rst = 1'b1;
        run_cycle(v, "reset");
    endtask

    function automatic in_t rand_in();
        in_t v;
        v        = '0;
        v.rst    = ($urandom_range(0, 99) < 2);
        v.pc     = $urandom() & 32'hFFFF_FFFC;
        v.br     = ($urandom_range(0, 99) < 15);
        v.bt     = $urandom() & 32'hFFFF_FFFC;
        v.j      = ($urandom_range(0, 99) < 15);
        v.jt     = $urandom() & 32'hFFFF_FFFC;
        v.luh    = ($urandom_range(0, 99) < 20);
        v.rdy    = ($urandom_range(0, 99) < 70);
        v.halt   = ($urandom_range(0, 99) < 5);
        v.resume = ($urandom_range(0, 99) < 30);
`ifdef PC_SEQUENCER_EXCEPTION_EN
        v.exc    = ($urandom_range(0, 99) < 3);
`endif
        return v;
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input logic br, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic luh,
                                input logic [31:0] e_pc, input logic e_pcw, input logic e_fl,
                                input logic [15:0] e_stall);
        vec_t t;
        t.in        = idle(pc);
        t.in.br     = br;
        t.in.bt     = bt;
        t.in.j      = j;
        t.in.jt     = jt;
        t.in.luh    = luh;
        t.e_pc_next = e_pc;
        t.e_pcw     = e_pcw;
        t.e_ifw     = e_pcw;
        t.e_fl      = e_fl;
        t.e_stall   = e_stall;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        in_t  v;

        // Single-cycle RUN behaviour, starting from a fresh reset (StallCycles = 0).
        tbl[0] = mk(32'h0000_0100, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0104, 1, 0, 16'd0);
        tbl[1] = mk(32'h0000_0100, 1, 32'h0000_0400, 1, 32'h0000_0800, 0, 32'h0000_0400, 1, 1, 16'd0);
        tbl[2] = mk(32'h0000_0200, 0, 32'h0,         1, 32'h0000_0800, 0, 32'h0000_0800, 1, 1, 16'd0);
        tbl[3] = mk(32'h0000_0300, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 16'd1);
        tbl[4] = mk(32'h0000_0300, 1, 32'h0000_1000, 0, 32'h0,         1, 32'h0000_1000, 1, 1, 16'd1);
        tbl[5] = mk(32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 1, 0, 16'd1);
        tbl[6] = mk(32'h0000_0300, 0, 32'h0,         1, 32'h0000_2000, 1, 32'h0000_2000, 1, 1, 16'd1);
        tbl[7] = mk(32'h0000_0300, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 16'd2);
        tbl[8] = mk(32'h7FFF_FFFC, 1, 32'hABCD_0000, 0, 32'h0,         0, 32'hABCD_0000, 1, 1, 16'd2);
        tbl[9] = mk(32'h1234_5678, 0, 32'h0,         0, 32'h0,         0, 32'h1234_567C, 1, 0, 16'd2);

        v = idle(32'h0);
        v.rst = 1'b1;
        drive(v);
        m_halted = 1'b0; m_waiting = 1'b0; m_pend = '0; m_stall = '0; m_epc = '0;
        #2;
        check("reset_pcwrite",   32'(bus.PCWrite),     32'h0);
        check("reset_ifidwrite", 32'(bus.IFIDWrite),   32'h0);
        check("reset_ifidflush", 32'(bus.IFIDFlush),   32'h0);
        check("reset_pcnext",    bus.PCNext,           32'h0);
        check("reset_stall",     32'(bus.StallCycles), 32'h0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_cycle(tbl[i].in, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_pcwrite_c", i), 32'(a_out.pc_write), 32'(tbl[i].e_pcw));
            check($sformatf("tbl%0d_ifidwrite_c", i), 32'(a_out.ifid_write), 32'(tbl[i].e_ifw));
            check($sformatf("tbl%0d_flush_c", i), 32'(a_out.ifid_flush), 32'(tbl[i].e_fl));
            if (tbl[i].e_pcw) check($sformatf("tbl%0d_pcnext_c", i), a_out.pc_next, tbl[i].e_pc_next);
            check($sformatf("tbl%0d_stall_c", i), 32'(a_stall), 32'(tbl[i].e_stall));
        end

        // I-cache miss for three cycles with a jump in the first.
        do_reset();
        v = idle(32'h100); v.rdy = 1'b0; v.j = 1'b1; v.jt = 32'h200;
        run_cycle(v, "miss_c1");
        check("miss_c1_pcwrite_c", 32'(a_out.pc_write), 32'h0);
        v = idle(32'h100); v.rdy = 1'b0;
        run_cycle(v, "miss_c2");
        check("miss_c2_pcwrite_c", 32'(a_out.pc_write), 32'h0);
        run_cycle(v, "miss_c3");
        check("miss_c3_pcwrite_c", 32'(a_out.pc_write), 32'h0);
        v = idle(32'h100);
        run_cycle(v, "miss_ready");
        check("miss_ready_pcnext_c", a_out.pc_next, 32'h200);
        check("miss_ready_flush_c", 32'(a_out.ifid_flush), 32'h1);
        check("miss_ready_stall_c", 32'(a_stall), 32'd3);

        // Latched jump is replaced by a later branch.
        do_reset();
        v = idle(32'h100); v.rdy = 1'b0; v.j = 1'b1; v.jt = 32'h300;
        run_cycle(v, "ovr_c1");
        v = idle(32'h100); v.rdy = 1'b0; v.br = 1'b1; v.bt = 32'h500;
        run_cycle(v, "ovr_c2");
        run_cycle(idle(32'h100), "ovr_ready");
        check("ovr_ready_pcnext_c", a_out.pc_next, 32'h500);

        // Latched branch is kept when a later jump arrives.
        do_reset();
        v = idle(32'h100); v.rdy = 1'b0; v.br = 1'b1; v.bt = 32'h600;
        run_cycle(v, "keep_c1");
        v = idle(32'h100); v.rdy = 1'b0; v.j = 1'b1; v.jt = 32'h700;
        run_cycle(v, "keep_c2");
        run_cycle(idle(32'h100), "keep_ready");
        check("keep_ready_pcnext_c", a_out.pc_next, 32'h600);

        // Halt pulse; Halt+Resume together must stay halted; Resume returns to RUN.
        do_reset();
        v = idle(32'h100); v.halt = 1'b1;
        run_cycle(v, "halt_pulse");
        check("halt_pulse_pcwrite_c", 32'(a_out.pc_write), 32'h0);
        check("halt_pulse_stall_c", 32'(a_stall), 32'd1);
        run_cycle(idle(32'h100), "halt_i1");
        run_cycle(idle(32'h100), "halt_i2");
        v = idle(32'h100); v.halt = 1'b1; v.resume = 1'b1;
        run_cycle(v, "halt_both");
        run_cycle(idle(32'h100), "halt_i3");
        check("halt_i3_pcwrite_c", 32'(a_out.pc_write), 32'h0);
        run_cycle(idle(32'h100), "halt_i4");
        v = idle(32'h100); v.resume = 1'b1;
        run_cycle(v, "halt_resume");
        check("halt_resume_pcwrite_c", 32'(a_out.pc_write), 32'h0);
        check("halt_resume_stall_c", 32'(a_stall), 32'd1);
        run_cycle(idle(32'h100), "halt_run");
        check("halt_run_pcnext_c", a_out.pc_next, 32'h104);
        check("halt_run_pcwrite_c", 32'(a_out.pc_write), 32'h1);

        // Reset during WAIT with a latched branch discards it.
        do_reset();
        v = idle(32'h500); v.rdy = 1'b0; v.br = 1'b1; v.bt = 32'h400;
        run_cycle(v, "rw_c1");
        v = idle(32'h500); v.rdy = 1'b0;
        run_cycle(v, "rw_c2");
        v = idle(32'h500); v.rst = 1'b1;
        run_cycle(v, "rw_reset");
        check("rw_reset_pcwrite_c", 32'(a_out.pc_write), 32'h0);
        check("rw_reset_flush_c", 32'(a_out.ifid_flush), 32'h0);
        check("rw_reset_pcnext_c", a_out.pc_next, 32'h0);
        run_cycle(idle(32'h500), "rw_after");
        check("rw_after_pcnext_c", a_out.pc_next, 32'h504);
        check("rw_after_flush_c", 32'(a_out.ifid_flush), 32'h0);

`ifdef PC_SEQUENCER_EXCEPTION_EN
        // Exception beats a load-use hazard and records EPC.
        do_reset();
        v = idle(32'h40); v.luh = 1'b1; v.exc = 1'b1;
        run_cycle(v, "exc_luh");
        check("exc_luh_pcnext_c", a_out.pc_next, 32'h8000_0180);
        check("exc_luh_pcwrite_c", 32'(a_out.pc_write), 32'h1);
        check("exc_luh_epc_c", bus.EPC, 32'h40);
        // Exception also leaves HALT.
        v = idle(32'h80); v.halt = 1'b1;
        run_cycle(v, "exc_halt_in");
        v = idle(32'h88); v.exc = 1'b1;
        run_cycle(v, "exc_from_halt");
        check("exc_from_halt_pcnext_c", a_out.pc_next, 32'h8000_0180);
        run_cycle(idle(32'h8000_0180), "exc_after");
        check("exc_after_pcnext_c", a_out.pc_next, 32'h8000_0184);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            run_cycle(rand_in(), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port PCCurrent, input, 32 bits: present PC register value.
REQ-004 SHALL have ports BranchTaken (in, 1) and BranchTarget (in, 32): resolved branch redirect from EX.
REQ-005 SHALL have ports Jump (in, 1) and JumpTarget (in, 32): jump redirect from ID.
REQ-006 SHALL have ports LoadUseHazard (in, 1), ICacheReady (in, 1), Halt (in, 1) and Resume (in, 1).
REQ-007 SHALL have ports PCNext (out, 32) and PCWrite (out, 1): drive the PC register.
REQ-008 SHALL have ports IFIDWrite (out, 1), IFIDFlush (out, 1) and StallCycles (out, 16).

Function
REQ-009 SHALL implement FSM states RUN, WAIT and HALT, with state and pending redirect held in registers.
REQ-010 In RUN with no events, SHALL output PCNext=PCCurrent+4 (mod 2^32), PCWrite=1, IFIDWrite=1 and IFIDFlush=0.
REQ-011 In RUN, SHALL apply redirect priority BranchTaken > Jump; the winner SHALL set PCNext=target, PCWrite=1 and IFIDFlush=1 in the same cycle.
REQ-012 In RUN with LoadUseHazard=1 and no redirect, SHALL output PCWrite=0 and IFIDWrite=0; a redirect SHALL override the hazard.
REQ-013 In RUN with ICacheReady=0, SHALL output PCWrite=0 and IFIDWrite=0 and go to WAIT next edge; any redirect present SHALL be latched (target plus valid).
REQ-014 In WAIT, SHALL hold PCWrite=0 and IFIDWrite=0, and latch any new redirect; a branch SHALL overwrite a latched jump, a jump SHALL NOT overwrite a latched branch.
REQ-015 In WAIT with ICacheReady=1, SHALL return to RUN; that cycle SHALL output PCNext=latched target (else PCCurrent+4), PCWrite=1 and IFIDFlush=latched valid, then clear the latch.
REQ-016 With Halt=1 in RUN or WAIT, SHALL enter HALT next edge and drive PCWrite=0 and IFIDWrite=0 that cycle; Halt SHALL outrank all other inputs.
REQ-017 In HALT, SHALL hold PCWrite=0 and IFIDWrite=0 until Resume=1, then return to RUN next edge; Halt and Resume both asserted SHALL stay in HALT.
REQ-018 SHALL increment StallCycles on every edge where PCWrite=0 and the state is not HALT, saturating at 16'hFFFF.

Reset
REQ-019 On Reset, SHALL asynchronously set state=RUN, clear the latch and set StallCycles=0.
REQ-020 While Reset=1, SHALL force PCWrite=0, IFIDWrite=0 and IFIDFlush=0, and PCNext SHALL equal 32'h00000000.
REQ-021 Reset mid-WAIT or mid-HALT SHALL discard the latched redirect.

Configuration
REQ-022 Macro PC_SEQUENCER_EXCEPTION_EN SHALL add ports ExcReq (in, 1) and EPC (out, 32).
REQ-023 With the macro defined, ExcReq SHALL outrank all inputs except Reset in every state, and SHALL set PCNext=32'h80000180, PCWrite=1, IFIDFlush=1, EPC<=PCCurrent, state<=RUN and clear the latch.
REQ-024 With the macro defined, EPC SHALL reset to 0.
REQ-025 Without the macro, SHALL have neither port nor exception logic, and behaviour SHALL be as REQ-009..021.

Structure
REQ-026 Shared package pc_seq_pkg SHALL hold the state encoding, the 32'h80000180 vector constant and the PC increment constant 4.
REQ-027 Sub-module pc_redirect_latch SHALL hold the pending redirect register and its overwrite priority.

Verification
REQ-028 PCCurrent=0x00000100, idle -> PCNext=0x00000104, PCWrite=1, StallCycles unchanged.
REQ-029 BranchTaken=1 (0x00000400) and Jump=1 (0x00000800) same cycle -> PCNext=0x00000400, IFIDFlush=1.
REQ-030 ICacheReady=0 for 3 cycles, Jump=1 (0x00000200) in cycle 1 -> PCWrite=0 ×3; ready cycle PCNext=0x00000200, IFIDFlush=1; StallCycles=3.
REQ-031 Halt pulse, then Resume after 5 cycles -> PCWrite=0 throughout HALT, StallCycles unchanged, RUN resumes with PCCurrent+4.
REQ-032 Reset asserted mid-WAIT with a latched branch -> outputs zeroed immediately; after release, no redirect is applied.
REQ-033 (macro on) ExcReq=1 during LoadUseHazard, PCCurrent=0x00000040 -> PCNext=0x80000180, EPC=0x00000040.
